// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants: S-box, round constants, FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   localparam int NR = 10;
   localparam int KW = 128;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ks_state_t;

   // Entry 0 sits in the top byte so the table reads in natural order.
   localparam logic [2047:0] c_sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return c_sbox_flat[(8'd255 - b) * 8 +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_key_sched_if.sv
// ============================================================================
// Module      : aes_inv_key_sched_if
// Description : Load request and round-key stream bundle for the key schedule
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_inv_key_sched_if;
   import aes_pkg::*;

   logic          start;
   logic [KW-1:0] key_in;
   logic          busy;
   logic          rk_valid;
   logic          rk_ready;
   logic [KW-1:0] rk_out;
   logic [3:0]    rk_round;
   logic          done;

   modport master (
      output start, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_round, done
   );

   modport slave (
      input  start, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_round, done
   );

endinterface

`default_nettype wire

// File: rtl/aes_subword.sv
// ============================================================================
// Module      : aes_subword
// Description : SubWord - four parallel forward S-box lookups on a 32-bit word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_subword
   import aes_pkg::*;
(
   input  wire logic [31:0] i_word,
   output logic      [31:0] o_word
);

   for (genvar g = 0; g < 4; g++) begin : g_byte
      assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
   end

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// ============================================================================
// Module      : aes_inv_key_sched
// Description : AES-128 reverse key schedule, emits round keys 10 down to 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_key_sched
   import aes_pkg::*;
(
   input  wire logic            clk,
   input  wire logic            rst,
   aes_inv_key_sched_if.slave   bus
);

   ks_state_t     r_state;
   logic [KW-1:0] r_key;
   logic [3:0]    r_round;
   logic          r_valid;
   logic          r_busy;
   logic          r_done;

   logic [31:0]   w_w0, w_w1, w_w2, w_w3;
   logic [31:0]   w_p0, w_p1, w_p2, w_p3;
   logic [31:0]   w_sub;
   logic          w_xfer;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   // Undo the forward recurrence: recover the previous round's words.
   assign w_p3 = w_w3 ^ w_w2;
   assign w_p2 = w_w2 ^ w_w1;
   assign w_p1 = w_w1 ^ w_w0;

   aes_subword u_subword (
      .i_word ({w_p3[23:0], w_p3[31:24]}),
      .o_word (w_sub)
   );

   assign w_p0   = w_w0 ^ w_sub ^ {rcon(r_round), 24'h0};
   assign w_xfer = r_valid & bus.rk_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_key   <= '0;
         r_round <= 4'd0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_key   <= bus.key_in;
                  r_round <= 4'(NR);
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_xfer) begin
                  if (r_round == 4'd0) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_key   <= {w_p0, w_p1, w_p2, w_p3};
                     r_round <= r_round - 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.rk_valid = r_valid;
   assign bus.rk_out   = r_key;
   assign bus.rk_round = r_round;
   assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
// ============================================================================
// Module      : tb_aes_inv_key_sched
// Description : Directed self-checking bench for the reverse AES key schedule
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_inv_key_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_inv_key_sched_if bus ();

   aes_inv_key_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc_used;
   logic [127:0] fips [0:10];
   logic [127:0] got  [0:10];
   logic [127:0] rnd_key;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Independent S-box: multiplicative inverse in GF(2^8) followed by the affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      logic [7:0] s, r;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s ^= r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] ref_subw(input logic [31:0] w);
      return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
   endfunction

   // Forward-expand the last beat (round 0) and compare each later round with the beats.
   task automatic model_check(input string tag);
      logic [127:0] k;
      logic [7:0]   rc;
      logic [31:0]  t, n0, n1, n2, n3;
      k  = got[10];
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         t  = ref_subw({k[23:0], k[31:24]}) ^ {rc, 24'h0};
         n0 = k[127:96] ^ t;
         n1 = k[95:64] ^ n0;
         n2 = k[63:32] ^ n1;
         n3 = k[31:0] ^ n2;
         k  = {n0, n1, n2, n3};
         chk(tag, got[10-r], k);
         rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
   endtask

   // mode 0: ready always high; 1: pseudo-random ready with a 5-cycle stall at round 5;
   // 2: ready high with start pulses on the round-7 and round-0 transfers.
   task automatic run_seq(input logic [127:0] key, input int mode);
      int           beats = 0;
      int           cyc = 0;
      int           stall = 0;
      logic [7:0]   lfsr = 8'h5a;
      logic         stalled = 1'b0;
      logic         rdy;
      logic [127:0] p_out = '0;
      logic [3:0]   p_round = 4'd0;
      bus.key_in   = key;
      bus.start    = 1'b1;
      bus.rk_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      while (beats < 11 && cyc < 300) begin
         chk("run_valid", bus.rk_valid, 1);
         chk("run_busy", bus.busy, 1);
         if (stalled) begin
            chk("stall_out", bus.rk_out, p_out);
            chk("stall_round", bus.rk_round, p_round);
         end
         rdy = 1'b1;
         if (mode == 1) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rdy  = lfsr[0];
            if (bus.rk_round == 4'd5 && stall < 5) begin
               rdy = 1'b0;
               stall++;
            end
         end
         bus.rk_ready = rdy;
         if (rdy && bus.rk_valid) begin
            got[beats] = bus.rk_out;
            chk("beat_round", bus.rk_round, 10 - beats);
            beats++;
            if (mode == 2 && (bus.rk_round == 4'd7 || bus.rk_round == 4'd0))
               bus.start = 1'b1;
         end
         stalled = !rdy;
         p_out   = bus.rk_out;
         p_round = bus.rk_round;
         cyc++;
         @(negedge clk);
         bus.start = 1'b0;
      end
      if (beats < 11) begin
         n_cmp++;
         n_bad++;
         $error("FAIL seq_timeout: observed %0d beats expected 11", beats);
      end
      cyc_used = cyc;
      chk("end_done", bus.done, 1);
      chk("end_valid", bus.rk_valid, 0);
      chk("end_busy", bus.busy, 0);
      chk("hold_round", bus.rk_round, 0);
      chk("hold_out", bus.rk_out, got[10]);
      bus.rk_ready = 1'b0;
      @(negedge clk);
      chk("done_pulse", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
   endtask

   task automatic chk_fips(input string tag);
      for (int b = 0; b < 11; b++) chk(tag, got[b], fips[10-b]);
   endtask

   initial begin
      fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.key_in   = '0;
      bus.rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.rk_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out", bus.rk_out, 0);
      chk("rst_round", bus.rk_round, 0);
      chk("rst_done", bus.done, 0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 A.1 vector, streaming
      run_seq(fips[10], 0);
      chk("fips_cycles", cyc_used, 11);
      chk_fips("fips_beat");

      // Backpressure
      run_seq(fips[10], 1);
      chk_fips("bp_beat");

      // Start pulses during RUN are ignored; a start right after done restarts
      run_seq(fips[10], 2);
      chk_fips("restart_beat");
      run_seq(fips[10], 0);
      chk_fips("restart_new");

      // Asynchronous reset while round 4 is presented
      bus.key_in   = fips[10];
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.rk_ready = 1'b1;
      for (int c = 0; c < 50 && bus.rk_round != 4'd4; c++) @(negedge clk);
      chk("pre_rst_round", bus.rk_round, 4);
      bus.rk_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", bus.rk_valid, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_out", bus.rk_out, 0);
      chk("arst_round", bus.rk_round, 0);
      chk("arst_done", bus.done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_busy", bus.busy, 0);
      run_seq(fips[10], 0);
      chk_fips("post_rst_beat");

      // All-zero round-10 key
      run_seq(128'h0, 0);
      chk("zero_r10", got[0], 128'h0);
      chk("zero_r9", got[1], {32'h55636363, 96'h0});
      model_check("zero_model");

      // Random key under backpressure
      rnd_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_seq(rnd_key, 1);
      chk("rnd_r10", got[0], rnd_key);
      model_check("rnd_model");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
